// File: rtl/divide_pkg.sv
// Types and constants shared by the unsigned divider and its reconstruct checker.
// Both ends import the same width constant so their operand sizes always agree.
package divide_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Operand width of the divider; the reconstruct stage defaults to the same value.
    localparam int DIV_WIDTH = DEFAULT_WIDTH;

    // Step counter width: counts 0..w-1, kept at least one bit wide.
    function automatic int count_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/divide_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder with a shift-add multiply; flags bad triples.
// Latency: out_valid exactly WIDTH edges after the accept edge; one triple per WIDTH+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, independent of out_ready.
module divide_reconstruct
    import divide_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   quotient,
    input  logic [WIDTH-1:0]   divisor,
    input  logic [WIDTH-1:0]   remainder,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] dividend,
    output logic               err
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    logic [DW-1:0]   acc;
    logic [DW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   count;
    logic            err_r;
    logic [DW-1:0]   acc_sum;

    // Cannot overflow: the largest result is 2^WIDTH*(2^WIDTH-1) < 2^DW.
    assign acc_sum  = mplier[0] ? (acc + mcand) : acc;
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            err_r     <= 1'b0;
            out_valid <= 1'b0;
            dividend  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= DW'(remainder);
                        mcand  <= DW'(divisor);
                        mplier <= quotient;
                        count  <= '0;
                        err_r  <= (divisor == '0) | (remainder >= divisor);
                        state  <= MUL;
                    end
                end
                MUL: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    // Fixed-length run: all WIDTH quotient bits are consumed, no early exit.
                    if (count == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        dividend  <= acc_sum;
                        err       <= err_r;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_reconstruct.sv
// Directed and exhaustive checks of divide_reconstruct at WIDTH=4.
module tb_divide_reconstruct;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   quotient = '0;
    logic [W-1:0]   divisor = '0;
    logic [W-1:0]   remainder = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] dividend;
    logic           err;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic [W-1:0]   q;
        logic [W-1:0]   d;
        logic [W-1:0]   r;
        logic [2*W-1:0] exp_div;
        logic           exp_err;
    } vec_t;

    vec_t vecs [7];

    divide_reconstruct #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Presents a triple at a negedge, then counts edges until out_valid is seen.
    task automatic send(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                        output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        quotient  = q;
        divisor   = d;
        remainder = r;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        quotient  = ~q;
        divisor   = ~d;
        remainder = ~r;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [2*W-1:0] mdl;
        logic           merr;

        vecs[0] = '{q: 4'd5,  d: 4'd3,  r: 4'd2,  exp_div: 8'd17,  exp_err: 1'b0};
        vecs[1] = '{q: 4'd15, d: 4'd15, r: 4'd14, exp_div: 8'd239, exp_err: 1'b0};
        vecs[2] = '{q: 4'd0,  d: 4'd9,  r: 4'd4,  exp_div: 8'd4,   exp_err: 1'b0};
        vecs[3] = '{q: 4'd7,  d: 4'd0,  r: 4'd5,  exp_div: 8'd5,   exp_err: 1'b1};
        vecs[4] = '{q: 4'd2,  d: 4'd3,  r: 4'd3,  exp_div: 8'd9,   exp_err: 1'b1};
        vecs[5] = '{q: 4'd1,  d: 4'd1,  r: 4'd0,  exp_div: 8'd1,   exp_err: 1'b0};
        vecs[6] = '{q: 4'd15, d: 4'd1,  r: 4'd0,  exp_div: 8'd15,  exp_err: 1'b0};

        rst = 1'b1;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dividend", 32'(dividend), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].q, vecs[i].d, vecs[i].r, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_dividend", i), 32'(dividend), 32'(vecs[i].exp_div));
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_in_ready_done", i), 32'(in_ready), 32'd0);
            drain($sformatf("vec%0d", i));
        end
        check("hold_after_handshake", 32'(dividend), 32'd15);

        // Backpressure: result held while a competing triple is offered.
        out_ready = 1'b0;
        send(4'd6, 4'd2, 4'd1, lat);
        check("bp_latency", 32'(lat), 32'd4);
        quotient  = 4'd9;
        divisor   = 4'd9;
        remainder = 4'd1;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_dividend", c), 32'(dividend), 32'd13);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        drain("bp_release");
        repeat (8) @(negedge clk);
        check("bp_no_ghost_result", 32'(out_valid), 32'd0);
        check("bp_dividend_held", 32'(dividend), 32'd13);

        // Async reset during the second MUL cycle.
        quotient  = 4'd12;
        divisor   = 4'd11;
        remainder = 4'd3;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_dividend", 32'(dividend), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (8) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            check("mid_rst_no_pulse", 32'(seen), 32'd0);
        end
        send(4'd3, 4'd3, 4'd0, lat);
        check("post_rst_latency", 32'(lat), 32'd4);
        check("post_rst_dividend", 32'(dividend), 32'd9);
        check("post_rst_err", 32'(err), 32'd0);
        drain("post_rst");

        // Exhaustive sweep against an arithmetic model.
        for (int t = 0; t < 4096; t++) begin
            logic [11:0] tv;
            tv   = 12'(t);
            mdl  = 8'(tv[11:8]) * 8'(tv[7:4]) + 8'(tv[3:0]);
            merr = (tv[7:4] == 4'd0) || (tv[3:0] >= tv[7:4]);
            send(tv[11:8], tv[7:4], tv[3:0], lat);
            check($sformatf("sweep_q%0d_d%0d_r%0d_dividend", tv[11:8], tv[7:4], tv[3:0]),
                  32'(dividend), 32'(mdl));
            check($sformatf("sweep_q%0d_d%0d_r%0d_err", tv[11:8], tv[7:4], tv[3:0]),
                  32'(err), 32'(merr));
            @(posedge clk);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/divide_reconstruct.md
Name: divide_reconstruct

Overview:
- Inverse of the small unsigned divider: takes a (quotient, divisor, remainder) triple and rebuilds dividend = quotient*divisor + remainder.
- Multiply is a sequential shift-add, one quotient bit per cycle.
- Used as a self-check/back-end stage behind the divider, and as a checker in divider verification.
- Valid/ready handshake on both sides; flags inconsistent triples.

Parameters:
- WIDTH, 4, bit width of quotient, divisor and remainder; dividend is 2*WIDTH bits; legal range 2..16

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input triple valid
- in_ready  output  1  block can accept a triple
- quotient  input  WIDTH  unsigned quotient
- divisor  input  WIDTH  unsigned divisor
- remainder  input  WIDTH  unsigned remainder
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- dividend  output  2*WIDTH  reconstructed dividend
- err  output  1  triple inconsistent (see below); valid with out_valid

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, any state): state=IDLE, in_ready=1 after reset, out_valid=0, dividend=0, err=0, internal acc/mcand/mplier/count=0.
- FSM states: IDLE, MUL, DONE.
- in_ready = (state==IDLE), combinational from state only; never depends on out_ready.
- IDLE, accept edge (in_valid & in_ready):
  - acc = zero-extended remainder; mcand = zero-extended divisor (2*WIDTH bits); mplier = quotient; count = 0.
  - err_r = (divisor==0) | (remainder >= divisor).
  - go to MUL.
  - Inputs are sampled only on this edge; later changes are ignored.
- MUL, each edge:
  - if mplier[0], acc = acc + mcand, modulo 2^(2*WIDTH); never overflows for legal widths, since max = 2^WIDTH*(2^WIDTH-1).
  - mcand <<= 1; mplier >>= 1; count++.
  - on the edge where count reaches WIDTH-1 (the WIDTH-th step), go to DONE.
- No early termination: latency is fixed. Exactly WIDTH edges after the accept edge, out_valid=1.
- DONE:
  - out_valid=1; dividend=acc and err=err_r, held stable until out_valid & out_ready.
  - On that edge, go to IDLE and out_valid drops.
  - No same-cycle re-accept: in_ready is low in DONE.
  - Throughput: one triple per WIDTH+2 cycles with out_ready tied high.
- Divisor==0: multiply still runs; dividend = remainder; err=1.
- remainder>=divisor with divisor!=0: dividend is still the arithmetic result; err=1.
- dividend/err outside DONE: hold the last delivered value (0 after reset).
- out_ready while not out_valid: ignored.
- in_valid while in MUL/DONE: ignored; the source must hold the triple until in_ready.
- Reset mid-MUL or mid-DONE: the result is discarded, no out_valid pulse; the block restarts in IDLE.

Decomposition:
- Shared package (divide_pkg):
  - state enum {IDLE, MUL, DONE};
  - DEFAULT_WIDTH=4 constant;
  - a function computing the count width, $clog2(WIDTH).
- The same package holds the divider's shared width constant so both ends agree.
- Single module; the datapath is one accumulator, one shifter and one counter, so no sub-module is warranted.

Test Plan:
- WIDTH=4, out_ready=1, q=5 d=3 r=2 -> out_valid exactly 4 edges after accept; dividend=17, err=0; in_ready back high the cycle after the handshake.
- q=15 d=15 r=14 -> dividend=239 (max legal), err=0; q=0 d=9 r=4 -> dividend=4, err=0.
- d=0 q=7 r=5 -> dividend=5, err=1; q=2 d=3 r=3 -> dividend=9, err=1.
- Backpressure: result for q=6 d=2 r=1 (13) ready, out_ready low for 5 cycles -> dividend=13 and out_valid stable, in_ready=0, a new in_valid is ignored; release -> one handshake, then IDLE.
- Async rst pulse during the 2nd MUL cycle -> all outputs 0 immediately, no out_valid; the next triple q=3 d=3 r=0 -> dividend=9 with correct latency.
- Random sweep of all 2^12 triples against a reference model -> dividend and err match.
